mc_control: RTL
===============

// Module: mc_control
// PURPOSE
//  Multicycle control FSM for the 32-bit MIPS-subset core. Sequences fetch/decode/execute/
//  mem/writeback and drives every datapath select, including ext_sel for the immediate
//  extender (sign / zero / lui). Sits between the IR opcode/funct fields and the datapath.
//  Memory accesses use a req/ready handshake, so waits of any length are tolerated.
// PARAMETERS
//  none (opcode, funct and select encodings are fixed constants in the shared defines)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous reset, active low
//  op         in   6  IR[31:26]
//  funct      in   6  IR[5:0], used only when op==6'h00
//  zero       in   1  ALU zero flag, same cycle
//  mem_ready  in   1  memory has completed the current rd/wr this cycle
//  mem_rd     out  1  memory read request, held until mem_ready
//  mem_wr     out  1  memory write request, held until mem_ready
//  iord       out  1  0 = address from PC, 1 = address from ALUOut
//  ir_wr      out  1  load IR (FETCH, only while mem_ready=1)
//  pc_en      out  1  PC write enable
//  pc_src     out  2  00 ALU, 01 ALUOut (branch target), 10 jump target
//  reg_wr     out  1  register-file write
//  reg_dst    out  1  0 = rt, 1 = rd
//  mem_to_reg out  1  0 = ALUOut, 1 = MDR
//  alu_src_a  out  1  0 = PC, 1 = rs
//  alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
//  alu_ctrl   out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  ext_sel    out  2  00 sign-extend, 01 zero-extend, 10 imm<<16 (lui)
//  illegal    out  1  one-cycle pulse in DECODE on unsupported op/funct
// BEHAVIOUR
//  - Moore outputs decoded from registered state. pc_en = pc_write | (pc_write_cond & zero).
//  - While rst_n=0: state=IDLE, all outputs 0. First edge after release: IDLE->FETCH.
//  - States/transitions (X = stay while mem_ready=0):
//    FETCH  : mem_rd, iord=0, src_a=0, src_b=01, alu add; X; on ready ir_wr, pc_en, pc_src=00 -> DECODE
//    DECODE : src_a=0, src_b=11, alu add, ext_sel=00 (branch target into ALUOut); dispatch on op:
//             00 R->EXEC_R, 23 lw/2B sw->MEMADR, 04 beq->BRANCH, 02 j->JUMP,
//             08 addi/0C andi/0D ori/0F lui->EXEC_I, others->FETCH with illegal=1
//    MEMADR : src_a=1, src_b=10, ext_sel=00, alu add -> MEMRD (lw) / MEMWR (sw)
//    MEMRD  : mem_rd, iord=1; X -> MEMWB     MEMWR : mem_wr, iord=1; X -> FETCH
//    MEMWB  : reg_wr, reg_dst=0, mem_to_reg=1 -> FETCH
//    EXEC_R : src_a=1, src_b=00, alu_ctrl from funct (20 add,22 sub,24 and,25 or,2A slt);
//             unsupported funct: illegal in DECODE, R dispatch suppressed -> FETCH
//    ALUWB  : reg_wr, reg_dst=1 (R) or 0 (I), mem_to_reg=0 -> FETCH (EXEC_R/EXEC_I -> ALUWB)
//    EXEC_I : src_a=1, src_b=10; addi: sign, add; andi: zero, and; ori: zero, or;
//             lui: ext_sel=10, or with rs forced 0 by datapath (alu or)
//    BRANCH : src_a=1, src_b=00, alu sub, pc_write_cond, pc_src=01 -> FETCH
//    JUMP   : pc_write, pc_src=10 -> FETCH
//  - Cycles: lw 5, sw 4, R/I 4, beq 3, j 3 (+ mem wait cycles each access).
//  - mem_rd/mem_wr never both 1; request stable and address select unchanged while waiting.
//  - mem_ready outside a memory state is ignored. Async reset mid-wait aborts the access;
//    restart from IDLE with no stray reg_wr/pc_en/ir_wr.
//  - Unused state encodings decode to outputs 0 and next state FETCH.
// STRUCTURE
//  - Shared defines (mc_ctrl_defs): state encoding (4 bits), OP_*/FN_* constants,
//    EXT_SIGN/EXT_ZERO/EXT_LUI, ALU_* and PCSRC_*/SRCB_* codes; used by datapath and extender mux.
//  - One sub-module: mc_alu_decoder (funct -> alu_ctrl, valid flag) for EXEC_R and DECODE illegal check.
//  - Single state register; next-state and output logic combinational.
// TESTING
//  1 reset low 3 cycles then high, mem_ready=1 -> all outputs 0 in reset; FETCH asserted 1 cycle later, IDLE->FETCH.
//  2 lw (op 23), mem_ready=1 always -> 5-cycle sequence; ext_sel=00 in MEMADR; reg_wr, mem_to_reg=1 in cycle 5.
//  3 FETCH with mem_ready low 3 cycles -> mem_rd held 4 cycles, ir_wr/pc_en only in 4th cycle.
//  4 beq op 04: zero=1 -> pc_en=1, pc_src=01 in BRANCH; repeat zero=0 -> pc_en=0.
//  5 ori 0D / lui 0F -> ext_sel=01 / 10, alu_ctrl=001, ALUWB reg_dst=0; addi 08 -> ext_sel=00, alu 010.
//  6 op 3F -> illegal pulse 1 cycle, back to FETCH; rst_n low during MEMWR wait -> no writes after release.

Source files
------------

// File: rtl/mc_ctrl_defs_pkg.sv
// rtl/mc_ctrl_defs_pkg.sv - shared encodings for the multicycle control path
// State, opcode/funct, extender, ALU and mux-select codes used by control and datapath.
package mc_ctrl_defs_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWR  = 4'd5,
      S_MEMWB  = 4'd6,
      S_EXEC_R = 4'd7,
      S_EXEC_I = 4'd8,
      S_ALUWB  = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] EXT_SIGN = 2'b00;
   localparam logic [1:0] EXT_ZERO = 2'b01;
   localparam logic [1:0] EXT_LUI  = 2'b10;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - R-type funct to ALU operation decode
// The valid flag lets DECODE reject unsupported functs before EXEC_R is entered.
module mc_alu_decoder
   import mc_ctrl_defs_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       valid
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      valid    = 1'b1;
      case (funct)
         FN_ADD:  alu_ctrl = ALU_ADD;
         FN_SUB:  alu_ctrl = ALU_SUB;
         FN_AND:  alu_ctrl = ALU_AND;
         FN_OR:   alu_ctrl = ALU_OR;
         FN_SLT:  alu_ctrl = ALU_SLT;
         default: valid    = 1'b0;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS-subset control FSM
// Moore outputs from the registered state; op/funct come from the stable IR.
module mc_control
   import mc_ctrl_defs_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_rd,
   output logic       mem_wr,
   output logic       iord,
   output logic       ir_wr,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       reg_wr,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] ext_sel,
   output logic       illegal
);

   state_t     r_state;
   state_t     w_next;
   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic [2:0] w_fn_alu;
   logic       w_fn_valid;

   mc_alu_decoder u_alu_dec (
      .funct    (funct),
      .alu_ctrl (w_fn_alu),
      .valid    (w_fn_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   assign pc_en = w_pc_write | (w_pc_write_cond & zero);

   always_comb begin
      w_next          = r_state;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      mem_rd          = 1'b0;
      mem_wr          = 1'b0;
      iord            = 1'b0;
      ir_wr           = 1'b0;
      pc_src          = PCSRC_ALU;
      reg_wr          = 1'b0;
      reg_dst         = 1'b0;
      mem_to_reg      = 1'b0;
      alu_src_a       = 1'b0;
      alu_src_b       = SRCB_RT;
      alu_ctrl        = ALU_AND;
      ext_sel         = EXT_SIGN;
      illegal         = 1'b0;
      case (r_state)
         S_IDLE: w_next = S_FETCH;
         S_FETCH: begin
            mem_rd    = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_ctrl  = ALU_ADD;
            if (mem_ready) begin
               ir_wr      = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: begin
            // Speculatively compute the branch target into ALUOut.
            alu_src_b = SRCB_IMM_SH2;
            alu_ctrl  = ALU_ADD;
            case (op)
               OP_RTYPE: begin
                  if (w_fn_valid) w_next = S_EXEC_R;
                  else begin
                     illegal = 1'b1;
                     w_next  = S_FETCH;
                  end
               end
               OP_LW, OP_SW:                    w_next = S_MEMADR;
               OP_BEQ:                          w_next = S_BRANCH;
               OP_J:                            w_next = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_EXEC_I;
               default: begin
                  illegal = 1'b1;
                  w_next  = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_ctrl  = ALU_ADD;
            w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            mem_rd = 1'b1;
            iord   = 1'b1;
            if (mem_ready) w_next = S_MEMWB;
         end
         S_MEMWR: begin
            mem_wr = 1'b1;
            iord   = 1'b1;
            if (mem_ready) w_next = S_FETCH;
         end
         S_MEMWB: begin
            reg_wr     = 1'b1;
            mem_to_reg = 1'b1;
            w_next     = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_ctrl  = w_fn_alu;
            w_next    = S_ALUWB;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            w_next    = S_ALUWB;
            case (op)
               OP_ANDI: begin ext_sel = EXT_ZERO; alu_ctrl = ALU_AND; end
               OP_ORI:  begin ext_sel = EXT_ZERO; alu_ctrl = ALU_OR;  end
               OP_LUI:  begin ext_sel = EXT_LUI;  alu_ctrl = ALU_OR;  end
               default: begin ext_sel = EXT_SIGN; alu_ctrl = ALU_ADD; end
            endcase
         end
         S_ALUWB: begin
            reg_wr  = 1'b1;
            reg_dst = (op == OP_RTYPE);
            w_next  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a       = 1'b1;
            alu_ctrl        = ALU_SUB;
            w_pc_write_cond = 1'b1;
            pc_src          = PCSRC_ALUOUT;
            w_next          = S_FETCH;
         end
         S_JUMP: begin
            w_pc_write = 1'b1;
            pc_src     = PCSRC_JUMP;
            w_next     = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

endmodule
